// File: rtl/atm_pkg.sv
// Shared definitions for the ATM PIN-entry slice: FSM state encoding,
// PIN geometry and default tuning constants.
package atm_pkg;

  localparam int PIN_DIGITS             = 4;
  localparam int PIN_BITS               = 4 * PIN_DIGITS;
  localparam int DEFAULT_MAX_ATTEMPTS   = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHECK,
    ST_GRANTED,
    ST_LOCKED
  } pin_state_t;

  // A keypad code is a usable digit only when it is valid BCD.
  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_timeout_counter.sv
// Inactivity timer: counts enabled cycles since the last restart and flags
// the cycle on which the count sits at TIMEOUT_CYCLES-1.
module pin_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count idle cycles; a restart always wins and the count saturates at LAST.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // The expiry flag is suppressed in a cycle that also restarts the timer.
  assign expire = enable && !restart && (count == LAST);

endmodule

// File: rtl/pin_entry.sv
// PIN entry controller: collects four BCD digits from a keypad, checks them
// against the card PIN, grants access, counts retries and retains the card
// after too many wrong entries. All outputs are registered.
module pin_entry
  import atm_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = DEFAULT_MAX_ATTEMPTS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cardIn,
  input  logic                key_valid,
  input  logic [3:0]          key_digit,
  input  logic                key_clear,
  input  logic                key_enter,
  input  logic [PIN_BITS-1:0] stored_pin,
  output logic                pin_valid,
  output logic                pin_fail,
  output logic                timeout,
  output logic                card_retained,
  output logic [1:0]          attempts_left,
  output logic [2:0]          digit_count,
  output logic                busy
);

  localparam logic [2:0] FULL_COUNT = 3'(PIN_DIGITS);
  localparam logic [1:0] MAX_TRIES  = 2'(MAX_ATTEMPTS);

  pin_state_t          state;
  logic [PIN_BITS-1:0] buffer;
  logic                key_event;
  logic                timer_enable;
  logic                timer_restart;
  logic                timer_expire;
  logic                card_pulled;

  assign key_event     = key_valid | key_clear | key_enter;
  assign timer_enable  = (state == ST_COLLECT);
  // Any state other than COLLECT holds the timer at zero, so entering
  // COLLECT always starts a fresh idle window.
  assign timer_restart = !timer_enable || key_event;
  assign card_pulled   = !cardIn &&
                         ((state == ST_COLLECT) || (state == ST_CHECK) ||
                          (state == ST_GRANTED));

  pin_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(timer_restart),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  // Main controller FSM with registered outputs.
  // NOTE: the digit buffer is reset along with the control state so a stale
  // PIN can never be compared after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      buffer        <= '0;
      pin_valid     <= 1'b0;
      pin_fail      <= 1'b0;
      timeout       <= 1'b0;
      card_retained <= 1'b0;
      attempts_left <= '0;
      digit_count   <= '0;
      busy          <= 1'b0;
    end else begin
      pin_fail <= 1'b0;
      timeout  <= 1'b0;

      if (card_pulled) begin
        state       <= ST_IDLE;
        busy        <= 1'b0;
        buffer      <= '0;
        digit_count <= '0;
        pin_valid   <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (cardIn) begin
              state         <= ST_COLLECT;
              busy          <= 1'b1;
              buffer        <= '0;
              digit_count   <= '0;
              attempts_left <= MAX_TRIES;
            end
          end

          ST_COLLECT: begin
            if (key_clear) begin
              buffer      <= '0;
              digit_count <= '0;
            end else if (key_enter) begin
              if (digit_count == FULL_COUNT) state <= ST_CHECK;
            end else if (key_valid) begin
              if (is_bcd(key_digit) && (digit_count < FULL_COUNT)) begin
                buffer      <= {buffer[PIN_BITS-5:0], key_digit};
                digit_count <= digit_count + 3'd1;
              end
            end else if (timer_expire) begin
              state       <= ST_IDLE;
              busy        <= 1'b0;
              timeout     <= 1'b1;
              buffer      <= '0;
              digit_count <= '0;
            end
          end

          ST_CHECK: begin
            if (buffer == stored_pin) begin
              state     <= ST_GRANTED;
              pin_valid <= 1'b1;
            end else if (attempts_left > 2'd1) begin
              state         <= ST_COLLECT;
              attempts_left <= attempts_left - 2'd1;
              pin_fail      <= 1'b1;
              buffer        <= '0;
              digit_count   <= '0;
            end else begin
              state         <= ST_LOCKED;
              attempts_left <= '0;
              card_retained <= 1'b1;
            end
          end

          ST_GRANTED, ST_LOCKED: begin
            // Hold: keypad ignored, only card removal (GRANTED) or reset exits.
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
